// File: rtl/pwm_bank_if.sv
// Bus bundle for pwm_bank: the simple valid/ready CPU peripheral bus.
// The CPU side is the master and the peripheral is the slave.
interface pwm_bank_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, wstrb, addr, wdata, input ready, rdata);
   modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: NCH independent PWM channels with PERIOD/DUTY/ENABLE registers on the valid/ready bus.
// Define PWM_BANK_SHADOW_EN to shadow PERIOD/DUTY and apply them at period wrap without clearing cnt.
module pwm_bank #(
   parameter int NCH   = 4,
   parameter int CNT_W = 16
) (
   input  logic           clk,
   input  logic           resetn,
   pwm_bank_if.slave      bus,
   output logic [NCH-1:0] out,
   output logic [NCH-1:0] wrap
);
   logic [NCH-1:0][CNT_W-1:0] per_q, per_d, duty_q, duty_d, cnt_q, cnt_d;
   logic [NCH-1:0][CNT_W-1:0] per_rd, duty_rd;
   logic [NCH-1:0]            en_q, en_d, out_q, out_d, wrap_q, wrap_d;
   logic [NCH-1:0]            per_wr, duty_wr, active, at_end, en_rise;
   logic                      ready_q, ready_d;
   logic [31:0]               rdata_q, rdata_d, rd_val, wmask;
   logic                      accept, wr;
   logic [5:0]                w;
   logic                      unused_addr;
`ifdef PWM_BANK_SHADOW_EN
   logic [NCH-1:0][CNT_W-1:0] shd_per_q, shd_per_d, shd_duty_q, shd_duty_d;
   assign per_rd  = shd_per_q;
   assign duty_rd = shd_duty_q;
`else
   assign per_rd  = per_q;
   assign duty_rd = duty_q;
`endif

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [31:0] mask);
      return (old & ~mask) | (data & mask);
   endfunction

   assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};
   assign w      = bus.addr[7:2];
   assign accept = bus.valid && !ready_q;
   assign wr     = accept && (|bus.wstrb);
   assign wmask  = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};

   always_comb begin
      rd_val = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (w == 6'(2*ch))   rd_val = 32'(per_rd[ch]);
         if (w == 6'(2*ch+1)) rd_val = 32'(duty_rd[ch]);
      end
      if (w == 6'(2*NCH)) rd_val = 32'(en_q);
   end

   always_comb begin
      ready_d = accept;
      // rdata captures the pre-write value, so a read-modify on the same edge sees the old register
      rdata_d = accept ? rd_val : rdata_q;
      en_d    = en_q;
      if (wr && (w == 6'(2*NCH))) en_d = NCH'(merge(32'(en_q), bus.wdata, wmask));
      en_rise = en_d & ~en_q;
      per_d   = per_q;
      duty_d  = duty_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      wrap_d  = wrap_q;
      per_wr  = '0;
      duty_wr = '0;
      active  = '0;
      at_end  = '0;
`ifdef PWM_BANK_SHADOW_EN
      shd_per_d  = shd_per_q;
      shd_duty_d = shd_duty_q;
`endif
      for (int ch = 0; ch < NCH; ch++) begin
         per_wr[ch]  = wr && (w == 6'(2*ch));
         duty_wr[ch] = wr && (w == 6'(2*ch+1));
         active[ch]  = en_q[ch] && (per_q[ch] != '0);
         at_end[ch]  = (cnt_q[ch] == per_q[ch]);
`ifdef PWM_BANK_SHADOW_EN
         if (per_wr[ch])  shd_per_d[ch]  = CNT_W'(merge(32'(shd_per_q[ch]), bus.wdata, wmask));
         if (duty_wr[ch]) shd_duty_d[ch] = CNT_W'(merge(32'(shd_duty_q[ch]), bus.wdata, wmask));
         // Apply at the wrap edge so the running period finishes with its old settings
         if (!active[ch] || at_end[ch]) begin
            per_d[ch]  = shd_per_d[ch];
            duty_d[ch] = shd_duty_d[ch];
         end
`else
         if (per_wr[ch])  per_d[ch]  = CNT_W'(merge(32'(per_q[ch]), bus.wdata, wmask));
         if (duty_wr[ch]) duty_d[ch] = CNT_W'(merge(32'(duty_q[ch]), bus.wdata, wmask));
`endif
         // Compare before incrementing so cnt never exceeds PERIOD, even at all-ones
         if (active[ch]) begin
            wrap_d[ch] = at_end[ch];
            cnt_d[ch]  = at_end[ch] ? '0 : cnt_q[ch] + CNT_W'(1);
            out_d[ch]  = (cnt_q[ch] < duty_q[ch]);
         end else begin
            wrap_d[ch] = 1'b0;
            cnt_d[ch]  = '0;
            out_d[ch]  = 1'b0;
         end
`ifndef PWM_BANK_SHADOW_EN
         if (per_wr[ch] || duty_wr[ch]) begin
            cnt_d[ch]  = '0;
            out_d[ch]  = 1'b0;
            wrap_d[ch] = 1'b0;
         end
`endif
         if (en_rise[ch]) cnt_d[ch] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         per_q      <= '0;
         duty_q     <= '0;
         cnt_q      <= '0;
         en_q       <= '0;
         out_q      <= '0;
         wrap_q     <= '0;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
`ifdef PWM_BANK_SHADOW_EN
         shd_per_q  <= '0;
         shd_duty_q <= '0;
`endif
      end else begin
         per_q      <= per_d;
         duty_q     <= duty_d;
         cnt_q      <= cnt_d;
         en_q       <= en_d;
         out_q      <= out_d;
         wrap_q     <= wrap_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
`ifdef PWM_BANK_SHADOW_EN
         shd_per_q  <= shd_per_d;
         shd_duty_q <= shd_duty_d;
`endif
      end
   end

   assign bus.ready = ready_q;
   assign bus.rdata = rdata_q;
   assign out       = out_q;
   assign wrap      = wrap_q;
endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Multi-channel successor to the single-channel square-wave peripheral on the simple valid/ready CPU bus.
- NCH independent PWM channels, each with a programmable period, duty and enable.
- One registered output bit and one period-wrap pulse per channel.
- Feeds LEDs, buzzers and motor drivers from the SoC peripheral bus.

Parameters:
- NCH, 4, number of channels (1..16).
- CNT_W, 16, counter/period/duty width in bits (1..32).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- valid  in  1  bus request.
- ready  out  1  bus acknowledge.
- wstrb  in  4  byte write strobes; all-zero means read.
- addr  in  32  byte address; only addr[7:2] decoded.
- wdata  in  32  write data.
- rdata  out  32  read data, valid while ready=1.
- out  out  NCH  PWM outputs, bit ch = channel ch.
- wrap  out  NCH  one-cycle pulse when channel counter wraps.

Behaviour:
- Reset (resetn=0 at a clock edge): all PERIOD, DUTY, ENABLE, counters, out, wrap, ready and rdata clear to 0. Reset mid-operation aborts any bus transfer with no ack.
- Register map, word index w = addr[7:2]:
  - w=2*ch: PERIOD[ch].
  - w=2*ch+1: DUTY[ch].
  - w=2*NCH: ENABLE, bits [NCH-1:0].
  - Any other w: reads 0, writes ignored.
- Registers are CNT_W bits wide. Bits above CNT_W (ENABLE: above NCH) ignore writes and read 0.
- Handshake: a transfer is accepted when valid=1 and ready=0.
  - ready=1 in the next cycle, for exactly one cycle.
  - valid held high yields one ack every two cycles.
- Write: on accept with |wstrb, byte lane i is updated iff wstrb[i].
- Read: rdata is loaded on accept with the register value before any same-cycle write. rdata holds its value when ready=0.
- Channel counter cnt[ch] (CNT_W bits):
  - ENABLE[ch]=0 or PERIOD[ch]=0: cnt=0, out=0, wrap=0.
  - Otherwise: cnt counts 0..PERIOD then returns to 0, so the period is PERIOD+1 cycles.
  - wrap[ch]=1 in the cycle after cnt==PERIOD.
- Output: out[ch] is registered and equals (cnt<DUTY) from the previous cycle (1-cycle latency).
  - DUTY=0: constant low.
  - DUTY>PERIOD: constant high.
- No arithmetic overflow: the comparison cnt==PERIOD precedes the increment, so cnt never exceeds PERIOD, including PERIOD = all-ones.
- Write side effects without the optional feature:
  - Any write to PERIOD[ch] or DUTY[ch] clears cnt[ch] to 0 and out[ch] to 0 in the same edge.
  - Writing ENABLE clears counters of channels whose bit changes 0→1.
  - A register write and a wrap in the same cycle: the write wins.
- Channels are fully independent; a write to one channel never disturbs another.

Optional Feature:
- Macro PWM_BANK_SHADOW_EN.
- Defined:
  - Bus writes to PERIOD/DUTY land in per-channel shadow registers, and reads return the shadow values.
  - Shadows are copied to the active registers on the edge where cnt[ch]==PERIOD (wrap), or immediately if the channel is disabled or the active PERIOD is 0.
  - Writes do not clear cnt, giving glitch-free duty updates.
- Undefined: no shadow registers; immediate update with counter clear as above.

Test Plan:
- Reset: hold resetn=0 3 cycles with valid=1 → ready=0, out=0, wrap=0; read all registers afterwards → 0.
- Basic PWM, ch0: PERIOD=9, DUTY=3, ENABLE=1 → out[0] high 3 / low 7 cycles, period 10; wrap[0] pulses every 10 cycles.
- Extremes, ch1: DUTY=0 → out[1] constant 0. DUTY=10 with PERIOD=9 → constant 1. PERIOD=0 → out 0, no wrap.
- Bus: byte write wstrb=4'b0010, wdata=0x0000AB00 to PERIOD[2] → readback 0x0000AB00. Write to w=63 ignored, read of w=63 → 0. Continuous valid → ready toggles 1/0.
- Mid-period write (feature off): ch0 running, write DUTY=5 when cnt=6 → cnt restarts at 0, out low next cycle, then 5 high / 5 low. Feature on: old waveform completes, new duty from the next period, no truncated pulse.
- Independence: ENABLE=4'b0101, channels 0 and 2 with PERIODs 4 and 7 → outputs at 5- and 8-cycle periods. Write to ch0 leaves ch2 phase unchanged.
